// File: rtl/ray_dispatcher.sv
// Raster-order primary ray generator and frame scheduler for a ray unit cluster.
// Optional stall statistics are enabled by defining RAY_DISPATCHER_STATS_EN.
module ray_dispatcher #(
  parameter int unsigned POSITION_WIDTH = 16,
  parameter int unsigned ADDRESS_WIDTH  = 32,
  parameter int unsigned COLUMN_COUNT   = 160,
  parameter int unsigned ROW_COUNT      = 120
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        frameStart,
  input  logic                        frameAbort,
  output logic                        frameBusy,
  output logic                        frameDone,
  input  logic [3*POSITION_WIDTH-1:0] cameraQ,
  input  logic [3*POSITION_WIDTH-1:0] cameraV0,
  input  logic [3*POSITION_WIDTH-1:0] cameraDX,
  input  logic [3*POSITION_WIDTH-1:0] cameraDY,
  input  logic [ADDRESS_WIDTH-1:0]    frameAddress,
  output logic                        rayStart,
  input  logic                        rayReady,
  input  logic                        rayBusy,
  output logic [3*POSITION_WIDTH-1:0] rayQ,
  output logic [3*POSITION_WIDTH-1:0] rayV,
  output logic [ADDRESS_WIDTH-1:0]    pixelAddress,
  output logic                        flush,
  output logic [31:0]                 stallCycles
);

  // Vectors are packed {z, y, x}, x in the least significant component.
  localparam int unsigned VecW = 3 * POSITION_WIDTH;
  localparam int unsigned ColW = (COLUMN_COUNT > 1) ? $clog2(COLUMN_COUNT) : 1;
  localparam int unsigned RowW = (ROW_COUNT > 1) ? $clog2(ROW_COUNT) : 1;
  localparam logic [ColW-1:0] ColLast = ColW'(COLUMN_COUNT - 1);
  localparam logic [RowW-1:0] RowLast = RowW'(ROW_COUNT - 1);

  typedef enum logic [2:0] {StIdle, StIssue, StDrain, StFlush, StDone} state_e;

  state_e                   state_q;
  logic [ColW-1:0]          col_q;
  logic [RowW-1:0]          row_q;
  logic [VecW-1:0]          row_base_q;
  logic [VecW-1:0]          dx_q;
  logic [VecW-1:0]          dy_q;
  logic [VecW-1:0]          ray_q_q;
  logic [VecW-1:0]          ray_v_q;
  logic [ADDRESS_WIDTH-1:0] addr_q;
  logic                     drain_seen_q;
  logic                     flush_q;
  logic                     done_q;
  logic                     busy_q;

  logic            accept;
  logic            col_end;
  logic            row_end;
  logic [VecW-1:0] next_row_v;

  // Per-component add; each component wraps independently.
  function automatic logic [VecW-1:0] vec_add(input logic [VecW-1:0] a,
                                              input logic [VecW-1:0] b);
    logic [VecW-1:0] s;
    s = '0;
    for (int i = 0; i < 3; i++) begin
      s[i*POSITION_WIDTH +: POSITION_WIDTH] = a[i*POSITION_WIDTH +: POSITION_WIDTH] +
                                              b[i*POSITION_WIDTH +: POSITION_WIDTH];
    end
    return s;
  endfunction

  assign accept     = (state_q == StIssue) && rayReady;
  assign col_end    = (col_q == ColLast);
  assign row_end    = (row_q == RowLast);
  assign next_row_v = vec_add(row_base_q, dy_q);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      col_q        <= '0;
      row_q        <= '0;
      row_base_q   <= '0;
      dx_q         <= '0;
      dy_q         <= '0;
      ray_q_q      <= '0;
      ray_v_q      <= '0;
      addr_q       <= '0;
      drain_seen_q <= 1'b0;
      flush_q      <= 1'b0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      flush_q <= 1'b0;
      done_q  <= 1'b0;
      case (state_q)
        StIdle: begin
          if (frameStart) begin
            col_q      <= '0;
            row_q      <= '0;
            row_base_q <= cameraV0;
            dx_q       <= cameraDX;
            dy_q       <= cameraDY;
            ray_q_q    <= cameraQ;
            ray_v_q    <= cameraV0;
            addr_q     <= frameAddress;
            busy_q     <= 1'b1;
            state_q    <= StIssue;
          end
        end
        StIssue: begin
          if (accept) begin
            if (!col_end) begin
              col_q   <= col_q + ColW'(1);
              ray_v_q <= vec_add(ray_v_q, dx_q);
              addr_q  <= addr_q + ADDRESS_WIDTH'(1);
            end else if (!row_end) begin
              col_q      <= '0;
              row_q      <= row_q + RowW'(1);
              row_base_q <= next_row_v;
              ray_v_q    <= next_row_v;
              addr_q     <= addr_q + ADDRESS_WIDTH'(1);
            end
          end
          if (frameAbort || (accept && col_end && row_end)) begin
            drain_seen_q <= 1'b0;
            state_q      <= StDrain;
          end
        end
        StDrain: begin
          // First DRAIN cycle is unconditional; idle cluster checked from the second on.
          if (!drain_seen_q) begin
            drain_seen_q <= 1'b1;
          end else if (!rayBusy) begin
            flush_q <= 1'b1;
            state_q <= StFlush;
          end
        end
        StFlush: begin
          done_q  <= 1'b1;
          state_q <= StDone;
        end
        StDone: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign rayStart     = accept;
  assign rayQ         = ray_q_q;
  assign rayV         = ray_v_q;
  assign pixelAddress = addr_q;
  assign flush        = flush_q;
  assign frameDone    = done_q;
  assign frameBusy    = busy_q;

`ifdef RAY_DISPATCHER_STATS_EN
  logic [31:0] stall_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stall_q <= '0;
    end else if ((state_q == StIdle) && frameStart) begin
      stall_q <= '0;
    end else if ((state_q == StIssue) && !rayReady && (stall_q != 32'hFFFF_FFFF)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stallCycles = stall_q;
`else
  assign stallCycles = 32'd0;
`endif

endmodule

// File: tb/tb_ray_dispatcher.sv
// Directed bench for ray_dispatcher on a 4x2 pixel grid.
module tb_ray_dispatcher;
  localparam int P = 16;
  localparam int A = 32;

`ifdef RAY_DISPATCHER_STATS_EN
  localparam logic [31:0] ExpStall = 32'd7;
`else
  localparam logic [31:0] ExpStall = 32'd0;
`endif

  logic           clock = 1'b0;
  logic           reset = 1'b0;
  logic           frameStart = 1'b0;
  logic           frameAbort = 1'b0;
  logic           frameBusy;
  logic           frameDone;
  logic [3*P-1:0] cameraQ = '0;
  logic [3*P-1:0] cameraV0 = '0;
  logic [3*P-1:0] cameraDX = '0;
  logic [3*P-1:0] cameraDY = '0;
  logic [A-1:0]   frameAddress = '0;
  logic           rayStart;
  logic           rayReady = 1'b0;
  logic           rayBusy = 1'b0;
  logic [3*P-1:0] rayQ;
  logic [3*P-1:0] rayV;
  logic [A-1:0]   pixelAddress;
  logic           flush;
  logic [31:0]    stallCycles;

  int total = 0;
  int bad = 0;

  always #5 clock = ~clock;

  ray_dispatcher #(
    .POSITION_WIDTH(P),
    .ADDRESS_WIDTH (A),
    .COLUMN_COUNT  (4),
    .ROW_COUNT     (2)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .frameStart  (frameStart),
    .frameAbort  (frameAbort),
    .frameBusy   (frameBusy),
    .frameDone   (frameDone),
    .cameraQ     (cameraQ),
    .cameraV0    (cameraV0),
    .cameraDX    (cameraDX),
    .cameraDY    (cameraDY),
    .frameAddress(frameAddress),
    .rayStart    (rayStart),
    .rayReady    (rayReady),
    .rayBusy     (rayBusy),
    .rayQ        (rayQ),
    .rayV        (rayV),
    .pixelAddress(pixelAddress),
    .flush       (flush),
    .stallCycles (stallCycles)
  );

  function automatic logic [3*P-1:0] vec(input logic [P-1:0] x, input logic [P-1:0] y,
                                         input logic [P-1:0] z);
    return {z, y, x};
  endfunction

  // Expected direction of pixel k for V0=(0,0,100), DX=(1,0,0), DY=(0,1,0), 4 columns.
  function automatic logic [3*P-1:0] pix_v(input int k);
    return vec(P'(k % 4), P'(k / 4), 16'd100);
  endfunction

  task automatic setup_std();
    cameraQ      = vec(16'd5, 16'd6, 16'd7);
    cameraV0     = vec(16'd0, 16'd0, 16'd100);
    cameraDX     = vec(16'd1, 16'd0, 16'd0);
    cameraDY     = vec(16'd0, 16'd1, 16'd0);
    frameAddress = 32'h1000;
    rayReady     = 1'b1;
    rayBusy      = 1'b0;
    frameAbort   = 1'b0;
    frameStart   = 1'b0;
  endtask

  task automatic test_reset();
    reset    = 1'b0;
    rayReady = 1'b1;
    #1;
    total++;
    if (rayStart !== 1'b0) begin bad++; $display("FAIL reset_rayStart got=%b want=0", rayStart); end
    total++;
    if (flush !== 1'b0 || frameDone !== 1'b0 || frameBusy !== 1'b0) begin
      bad++; $display("FAIL reset_flags got=%b%b%b want=000", flush, frameDone, frameBusy);
    end
    total++;
    if (rayQ !== '0 || rayV !== '0) begin
      bad++; $display("FAIL reset_ray got=%h/%h want=0/0", rayQ, rayV);
    end
    total++;
    if (pixelAddress !== '0 || stallCycles !== '0) begin
      bad++; $display("FAIL reset_addr_stall got=%h/%h want=0/0", pixelAddress, stallCycles);
    end
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_basic();
    setup_std();
    @(negedge clock);
    frameStart = 1'b1;
    #1;
    total++;
    if (frameBusy !== 1'b0) begin bad++; $display("FAIL basic_idle_busy got=%b want=0", frameBusy); end
    for (int t = 1; t <= 13; t++) begin
      @(negedge clock);
      frameStart = 1'b0;
      if (t == 2) begin
        cameraV0 = vec(16'd9, 16'd9, 16'd9);
        cameraDX = vec(16'd3, 16'd3, 16'd3);
        cameraDY = vec(16'd5, 16'd5, 16'd5);
        cameraQ = '0;
        frameAddress = '0;
      end
      #1;
      if (t <= 8) begin
        total++;
        if (rayV !== pix_v(t - 1) || pixelAddress !== 32'h1000 + 32'(t - 1) ||
            rayQ !== vec(16'd5, 16'd6, 16'd7)) begin
          bad++;
          $display("FAIL basic_ray t=%0d got=%h/%h/%h want=%h/%h/%h", t, rayV, pixelAddress, rayQ,
                   pix_v(t - 1), 32'h1000 + 32'(t - 1), vec(16'd5, 16'd6, 16'd7));
        end
      end
      total++;
      if (rayStart !== (t <= 8) || flush !== (t == 11) || frameDone !== (t == 12) ||
          frameBusy !== (t <= 12)) begin
        bad++;
        $display("FAIL basic_ctrl t=%0d got start/flush/done/busy=%b%b%b%b want=%b%b%b%b", t,
                 rayStart, flush, frameDone, frameBusy, t <= 8, t == 11, t == 12, t <= 12);
      end
    end
  endtask

  task automatic test_stall();
    int  k;
    bit  seen;
    setup_std();
    k = 0;
    @(negedge clock);
    frameStart = 1'b1;
    for (int t = 1; t <= 16; t++) begin
      @(negedge clock);
      frameStart = 1'b0;
      rayReady = (t % 2 == 1) || (t == 16);
      #1;
      total++;
      if (t <= 15) begin
        if (rayStart !== rayReady || rayV !== pix_v(k) || pixelAddress !== 32'h1000 + 32'(k)) begin
          bad++;
          $display("FAIL stall_ray t=%0d got=%b/%h/%h want=%b/%h/%h", t, rayStart, rayV,
                   pixelAddress, rayReady, pix_v(k), 32'h1000 + 32'(k));
        end
        if (rayReady) k++;
      end else if (rayStart !== 1'b0) begin
        bad++; $display("FAIL stall_extra_ray got=%b want=0", rayStart);
      end
    end
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clock);
      #1;
      seen = frameDone;
    end
    total++;
    if (!seen) begin bad++; $display("FAIL stall_done_timeout got=0 want=1"); end
    total++;
    if (stallCycles !== ExpStall) begin
      bad++; $display("FAIL stall_count got=%0d want=%0d", stallCycles, ExpStall);
    end
    @(negedge clock);
    @(negedge clock);
    #1;
    total++;
    if (stallCycles !== ExpStall || frameBusy !== 1'b0) begin
      bad++; $display("FAIL stall_hold got=%0d/%b want=%0d/0", stallCycles, frameBusy, ExpStall);
    end
  endtask

  task automatic test_busy();
    setup_std();
    @(negedge clock);
    frameStart = 1'b1;
    for (int t = 1; t <= 22; t++) begin
      @(negedge clock);
      frameStart = 1'b0;
      rayBusy = (t >= 9) && (t <= 18);
      #1;
      total++;
      if (rayStart !== (t <= 8) || flush !== (t == 20) || frameDone !== (t == 21)) begin
        bad++;
        $display("FAIL busy_drain t=%0d got start/flush/done=%b%b%b want=%b%b%b", t, rayStart,
                 flush, frameDone, t <= 8, t == 20, t == 21);
      end
    end
    rayBusy = 1'b0;
  endtask

  task automatic test_abort();
    int n;
    setup_std();
    n = 0;
    @(negedge clock);
    frameStart = 1'b1;
    for (int t = 1; t <= 8; t++) begin
      @(negedge clock);
      frameStart = 1'b0;
      frameAbort = (t == 3);
      #1;
      if (rayStart === 1'b1) n++;
      if (t == 3) begin
        total++;
        if (rayV !== pix_v(2)) begin bad++; $display("FAIL abort_ray3 got=%h want=%h", rayV, pix_v(2)); end
      end
      total++;
      if (rayStart !== (t <= 3) || flush !== (t == 6) || frameDone !== (t == 7) ||
          frameBusy !== (t <= 7)) begin
        bad++;
        $display("FAIL abort_ctrl t=%0d got start/flush/done/busy=%b%b%b%b want=%b%b%b%b", t,
                 rayStart, flush, frameDone, frameBusy, t <= 3, t == 6, t == 7, t <= 7);
      end
    end
    frameAbort = 1'b0;
    total++;
    if (n != 3) begin bad++; $display("FAIL abort_ray_count got=%0d want=3", n); end
  endtask

  task automatic test_wrap();
    logic [P-1:0] xs [8];
    xs = '{16'h0001, 16'h8000, 16'hFFFF, 16'h7FFE, 16'h0000, 16'h7FFF, 16'hFFFE, 16'h7FFD};
    setup_std();
    cameraV0     = vec(16'h0001, 16'h0, 16'h0);
    cameraDX     = vec(16'h7FFF, 16'h0, 16'h0);
    cameraDY     = vec(16'hFFFF, 16'h0, 16'h0);
    frameAddress = 32'hFFFF_FFFF;
    @(negedge clock);
    frameStart = 1'b1;
    for (int t = 1; t <= 13; t++) begin
      @(negedge clock);
      frameStart = 1'b0;
      #1;
      if (t <= 8) begin
        total++;
        if (rayV !== vec(xs[t-1], 16'h0, 16'h0) || pixelAddress !== 32'hFFFF_FFFF + 32'(t - 1)) begin
          bad++;
          $display("FAIL wrap_ray t=%0d got=%h/%h want=%h/%h", t, rayV, pixelAddress,
                   vec(xs[t-1], 16'h0, 16'h0), 32'hFFFF_FFFF + 32'(t - 1));
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    setup_std();
    @(negedge clock);
    frameStart = 1'b1;
    for (int t = 1; t <= 3; t++) begin
      @(negedge clock);
      frameStart = 1'b0;
    end
    reset = 1'b0;
    #1;
    total++;
    if ({rayStart, flush, frameDone, frameBusy, rayQ, rayV, pixelAddress, stallCycles} !== '0) begin
      bad++;
      $display("FAIL midreset_outputs got=%b%b%b%b/%h/%h/%h/%h want=all zero", rayStart, flush,
               frameDone, frameBusy, rayQ, rayV, pixelAddress, stallCycles);
    end
    @(negedge clock);
    reset = 1'b1;
    #1;
    total++;
    if (rayStart !== 1'b0 || frameBusy !== 1'b0 || flush !== 1'b0) begin
      bad++; $display("FAIL midreset_idle got=%b%b%b want=000", rayStart, frameBusy, flush);
    end
    @(negedge clock);
    frameStart = 1'b1;
    for (int t = 1; t <= 14; t++) begin
      @(negedge clock);
      frameStart = (t == 9) || (t == 12);
      #1;
      if (t == 1) begin
        total++;
        if (rayV !== pix_v(0) || pixelAddress !== 32'h1000) begin
          bad++; $display("FAIL midreset_restart got=%h/%h want=%h/00001000", rayV, pixelAddress, pix_v(0));
        end
      end
      total++;
      if (rayStart !== (t <= 8) || flush !== (t == 11) || frameDone !== (t == 12) ||
          frameBusy !== (t <= 12)) begin
        bad++;
        $display("FAIL midreset_ctrl t=%0d got start/flush/done/busy=%b%b%b%b want=%b%b%b%b", t,
                 rayStart, flush, frameDone, frameBusy, t <= 8, t == 11, t == 12, t <= 12);
      end
    end
    frameStart = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_busy();
    test_abort();
    test_wrap();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
